sound_sequencer: RTL and testbench



---
 rtl/sound_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_sound_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// rtl/sound_sequencer.sv - multi-event square-wave sound sequencer with priority, preemption and mute
//
// Plays a multi-note square-wave pattern for each game event. Events are
// rising edges of goodColl_i / badColl_i, or a change of direction_i to a
// non-zero value. A simultaneous event picks the highest class (bad > good > click).
// button_i rising edges toggle mute.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   goodColl_i   food-eaten event input
//   badColl_i    wall/self collision event input
//   button_i     debounced mute toggle button
//   direction_i  one-hot snake direction
//   soundOut     DAC sample (AMP or 0)
//   busy_o       high while a pattern is in TONE or GAP
//   mode_o       1 = sound enabled, 0 = muted
module sound_sequencer #(
    parameter int N         = 8,
    parameter int PERIOD_W  = 16,
    parameter int DUR_W     = 20,
    parameter int BASE_HP   = 1000,
    parameter int NOTE_DUR  = 250000,
    parameter int CLICK_DUR = 62500,
    parameter int GAP_DUR   = 31250,
    parameter int AMP       = 2**N-1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         goodColl_i,
    input  logic         badColl_i,
    input  logic         button_i,
    input  logic [3:0]   direction_i,
    output logic [N-1:0] soundOut,
    output logic         busy_o,
    output logic         mode_o
);

    localparam logic [N-1:0] AMP_V = N'(AMP);

    localparam logic [1:0] PRI_CLICK = 2'd0;
    localparam logic [1:0] PRI_GOOD  = 2'd1;
    localparam logic [1:0] PRI_BAD   = 2'd2;

    // Note half-periods, already scaled by BASE_HP
    localparam logic [PERIOD_W-1:0] HP_BAD0  = PERIOD_W'(BASE_HP * 12);
    localparam logic [PERIOD_W-1:0] HP_BAD1  = PERIOD_W'(BASE_HP * 15);
    localparam logic [PERIOD_W-1:0] HP_BAD2  = PERIOD_W'(BASE_HP * 20);
    localparam logic [PERIOD_W-1:0] HP_GOOD0 = PERIOD_W'(BASE_HP * 6);
    localparam logic [PERIOD_W-1:0] HP_GOOD1 = PERIOD_W'(BASE_HP * 4);
    localparam logic [PERIOD_W-1:0] HP_CLICK = PERIOD_W'(BASE_HP * 2);

    localparam logic [DUR_W-1:0] NOTE_LAST  = DUR_W'(NOTE_DUR - 1);
    localparam logic [DUR_W-1:0] CLICK_LAST = DUR_W'(CLICK_DUR - 1);
    localparam logic [DUR_W-1:0] GAP_LAST   = DUR_W'(GAP_DUR - 1);

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    state_t              state;
    logic [1:0]          pat;
    logic [1:0]          note_idx;
    logic [PERIOD_W-1:0] hp_cnt;
    logic [DUR_W-1:0]    dur_cnt;
    logic                phase;
    logic                good_q, bad_q, btn_q;
    logic [3:0]          dir_q;

    logic                good_ev, bad_ev, btn_ev, dir_ev;
    logic                mode_next, ev_any;
    logic [1:0]          ev_pri;
    logic [PERIOD_W-1:0] hp_sel;
    logic [PERIOD_W-1:0] hp_last;
    logic [DUR_W-1:0]    tone_last;
    logic [1:0]          idx_last;

    always_comb begin
        good_ev   = goodColl_i & ~good_q;
        bad_ev    = badColl_i & ~bad_q;
        btn_ev    = button_i & ~btn_q;
        dir_ev    = (direction_i != dir_q) && (direction_i != 4'b0000);
        // The mode toggle takes effect before event acceptance on the same edge
        mode_next = mode_o ^ btn_ev;
        ev_any    = mode_next & (good_ev | bad_ev | dir_ev);
        ev_pri    = bad_ev ? PRI_BAD : (good_ev ? PRI_GOOD : PRI_CLICK);

        hp_sel    = HP_CLICK;
        tone_last = CLICK_LAST;
        idx_last  = 2'd0;
        case (pat)
            PRI_BAD: begin
                tone_last = NOTE_LAST;
                idx_last  = 2'd2;
                case (note_idx)
                    2'd0:    hp_sel = HP_BAD0;
                    2'd1:    hp_sel = HP_BAD1;
                    default: hp_sel = HP_BAD2;
                endcase
            end
            PRI_GOOD: begin
                tone_last = NOTE_LAST;
                idx_last  = 2'd1;
                hp_sel    = (note_idx == 2'd0) ? HP_GOOD0 : HP_GOOD1;
            end
            default: ;
        endcase
        hp_last = hp_sel - PERIOD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pat      <= PRI_CLICK;
            note_idx <= 2'd0;
            hp_cnt   <= '0;
            dur_cnt  <= '0;
            phase    <= 1'b0;
            good_q   <= 1'b0;
            bad_q    <= 1'b0;
            btn_q    <= 1'b0;
            dir_q    <= 4'b0000;
            soundOut <= '0;
            busy_o   <= 1'b0;
            mode_o   <= 1'b1;
        end else begin
            // Edge copies track inputs even while muted so unmuting replays nothing
            good_q <= goodColl_i;
            bad_q  <= badColl_i;
            btn_q  <= button_i;
            dir_q  <= direction_i;
            mode_o <= mode_next;

            if (btn_ev && mode_o) begin
                // Muting aborts any playback
                state    <= IDLE;
                hp_cnt   <= '0;
                dur_cnt  <= '0;
                phase    <= 1'b0;
                soundOut <= '0;
                busy_o   <= 1'b0;
            end else if (ev_any && (state == IDLE || ev_pri >= pat)) begin
                // New pattern or equal/higher-priority preemption; lower ones are dropped
                state    <= TONE;
                pat      <= ev_pri;
                note_idx <= 2'd0;
                hp_cnt   <= '0;
                dur_cnt  <= '0;
                phase    <= 1'b1;
                soundOut <= AMP_V;
                busy_o   <= 1'b1;
            end else begin
                case (state)
                    TONE: begin
                        if (dur_cnt == tone_last) begin
                            dur_cnt  <= '0;
                            hp_cnt   <= '0;
                            soundOut <= '0;
                            if (note_idx != idx_last) begin
                                state  <= GAP;
                                busy_o <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                            end
                        end else begin
                            dur_cnt <= dur_cnt + DUR_W'(1);
                            busy_o  <= 1'b1;
                            if (hp_cnt == hp_last) begin
                                hp_cnt   <= '0;
                                phase    <= ~phase;
                                soundOut <= phase ? '0 : AMP_V;
                            end else begin
                                hp_cnt   <= hp_cnt + PERIOD_W'(1);
                                soundOut <= phase ? AMP_V : '0;
                            end
                        end
                    end
                    GAP: begin
                        busy_o <= 1'b1;
                        if (dur_cnt == GAP_LAST) begin
                            state    <= TONE;
                            note_idx <= note_idx + 2'd1;
                            hp_cnt   <= '0;
                            dur_cnt  <= '0;
                            phase    <= 1'b1;
                            soundOut <= AMP_V;
                        end else begin
                            dur_cnt  <= dur_cnt + DUR_W'(1);
                            soundOut <= '0;
                        end
                    end
                    default: begin
                        soundOut <= '0;
                        busy_o   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// tb/tb_sound_sequencer.sv - table-driven self-checking bench for sound_sequencer
module tb_sound_sequencer;

    localparam int N = 8;
    localparam logic [7:0] A = 8'd255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       goodColl_i = 1'b0;
    logic       badColl_i = 1'b0;
    logic       button_i = 1'b0;
    logic [3:0] direction_i = 4'b0000;
    logic [N-1:0] soundOut;
    logic       busy_o;
    logic       mode_o;

    int checks = 0;
    int errors = 0;

    sound_sequencer #(
        .N(8), .PERIOD_W(16), .DUR_W(20), .BASE_HP(2),
        .NOTE_DUR(16), .CLICK_DUR(4), .GAP_DUR(4), .AMP(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .goodColl_i(goodColl_i),
        .badColl_i(badColl_i),
        .button_i(button_i),
        .direction_i(direction_i),
        .soundOut(soundOut),
        .busy_o(busy_o),
        .mode_o(mode_o)
    );

    always #5 clk = ~clk;

    // Inputs are held for n cycles; the outputs must hold the expected values after each of those edges
    typedef struct {
        logic       rst;
        logic       good;
        logic       bad;
        logic       btn;
        logic [3:0] dir;
        int         n;
        logic [7:0] snd;
        logic       busy;
        logic       mode;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic r, input logic g, input logic b, input logic bt,
                     input logic [3:0] d, input int n, input logic [7:0] s,
                     input logic bz, input logic m);
        vec_t e;
        e.rst = r; e.good = g; e.bad = b; e.btn = bt; e.dir = d;
        e.n = n; e.snd = s; e.busy = bz; e.mode = m;
        tbl.push_back(e);
    endtask

    task automatic measure(input int retrig, input int exp_cnt, input int id);
        int cnt;
        goodColl_i = 1'b1;
        @(posedge clk); #1;
        cnt = busy_o ? 1 : 0;
        for (int c = 1; c < 200 && busy_o; c++) begin
            goodColl_i = (c == retrig);
            @(posedge clk); #1;
            if (busy_o) cnt++;
        end
        goodColl_i = 1'b0;
        checks++;
        if (busy_o) begin
            errors++;
            $display("FAIL busy_len%0d: busy_o still high after 200 cycles, required low", id);
        end else if (cnt != exp_cnt) begin
            errors++;
            $display("FAIL busy_len%0d: got %0d busy cycles, required %0d", id, cnt, exp_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        v(1,0,0,0,4'h0, 2, 0,0,1);
        v(0,0,0,0,4'h0, 2, 0,0,1);
        // good pattern: 12 high, 4 low, gap 4, 8 high, 8 low
        v(0,1,0,0,4'h0, 1, A,1,1);
        v(0,0,0,0,4'h0,11, A,1,1);
        v(0,0,0,0,4'h0, 4, 0,1,1);
        v(0,0,0,0,4'h0, 4, 0,1,1);
        v(0,0,0,0,4'h0, 8, A,1,1);
        v(0,0,0,0,4'h0, 8, 0,1,1);
        v(0,0,0,0,4'h0, 2, 0,0,1);
        // good and bad together: bad pattern, 56 busy cycles
        v(0,1,1,0,4'h0, 1, A,1,1);
        v(0,0,0,0,4'h0,15, A,1,1);
        v(0,0,0,0,4'h0, 4, 0,1,1);
        v(0,0,0,0,4'h0,16, A,1,1);
        v(0,0,0,0,4'h0, 4, 0,1,1);
        v(0,0,0,0,4'h0,16, A,1,1);
        v(0,0,0,0,4'h0, 2, 0,0,1);
        // direction clicks, change to zero is silent
        v(0,0,0,0,4'h1, 1, A,1,1);
        v(0,0,0,0,4'h1, 3, A,1,1);
        v(0,0,0,0,4'h1, 2, 0,0,1);
        v(0,0,0,0,4'h4, 1, A,1,1);
        v(0,0,0,0,4'h4, 3, A,1,1);
        v(0,0,0,0,4'h4, 2, 0,0,1);
        v(0,0,0,0,4'h0, 3, 0,0,1);
        v(0,0,0,0,4'h1, 4, A,1,1);
        v(0,0,0,0,4'h1, 1, 0,0,1);
        // good arriving on the click's final count preempts it
        v(0,0,0,0,4'h2, 1, A,1,1);
        v(0,0,0,0,4'h2, 3, A,1,1);
        v(0,1,0,0,4'h2, 1, A,1,1);
        v(0,0,0,0,4'h2,11, A,1,1);
        v(0,0,0,0,4'h2, 4, 0,1,1);
        v(0,0,0,0,4'h2, 4, 0,1,1);
        v(0,0,0,0,4'h2, 8, A,1,1);
        v(0,0,0,0,4'h2, 8, 0,1,1);
        v(0,0,0,0,4'h2, 2, 0,0,1);
        // click during good dropped, bad at cycle 10 restarts
        v(0,1,0,0,4'h2, 1, A,1,1);
        v(0,0,0,0,4'h2, 4, A,1,1);
        v(0,0,0,0,4'h1, 1, A,1,1);
        v(0,0,0,0,4'h1, 4, A,1,1);
        v(0,0,1,0,4'h1, 1, A,1,1);
        v(0,0,0,0,4'h1,15, A,1,1);
        v(0,0,0,0,4'h1, 4, 0,1,1);
        // mute during bad note 2, events ignored, held input not replayed
        v(0,0,0,0,4'h1, 3, A,1,1);
        v(0,0,0,1,4'h1, 1, 0,0,0);
        v(0,0,0,0,4'h1, 3, 0,0,0);
        v(0,1,0,0,4'h1, 1, 0,0,0);
        v(0,1,0,0,4'h1, 3, 0,0,0);
        v(0,1,0,1,4'h1, 1, 0,0,1);
        v(0,1,0,0,4'h1, 2, 0,0,1);
        v(0,0,0,0,4'h1, 1, 0,0,1);
        // toggle to ON with an event on the same edge plays; reset during gap
        v(0,0,0,1,4'h1, 1, 0,0,0);
        v(0,0,0,0,4'h1, 1, 0,0,0);
        v(0,1,0,1,4'h1, 1, A,1,1);
        v(0,0,0,0,4'h1,11, A,1,1);
        v(0,0,0,0,4'h1, 4, 0,1,1);
        v(0,0,0,0,4'h1, 2, 0,1,1);
        v(1,0,0,0,4'h0, 1, 0,0,1);
        v(0,0,0,0,4'h0, 3, 0,0,1);
        // toggle to OFF with an event ignores it; reset while muted restores ON
        v(0,0,1,1,4'h0, 1, 0,0,0);
        v(0,0,0,0,4'h0, 2, 0,0,0);
        v(1,0,0,0,4'h0, 1, 0,0,1);
        v(0,0,0,0,4'h0, 2, 0,0,1);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                rst         = tbl[i].rst;
                goodColl_i  = tbl[i].good;
                badColl_i   = tbl[i].bad;
                button_i    = tbl[i].btn;
                direction_i = tbl[i].dir;
                @(posedge clk); #1;
                checks++;
                if (soundOut !== tbl[i].snd || busy_o !== tbl[i].busy || mode_o !== tbl[i].mode) begin
                    errors++;
                    $display("FAIL vec%0d cyc%0d: got snd=%0d busy=%0b mode=%0b, required snd=%0d busy=%0b mode=%0b",
                             i, c, soundOut, busy_o, mode_o, tbl[i].snd, tbl[i].busy, tbl[i].mode);
                end
            end
        end
        rst = 1'b0; goodColl_i = 1'b0; badColl_i = 1'b0; button_i = 1'b0;

        // good pattern length, then equal-priority retrigger at the start of note 2
        measure(-1, 36, 0);
        measure(20, 56, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
